// File: rtl/mem_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// The mem_arbiter block honours the optional macro ARB_ROUND_ROBIN_EN.
package mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    // Address map decoded by the memory interface behind the arbiter
    localparam logic [31:0] ROM_BASE = 32'h0001_0000;
    localparam logic [31:0] RAM_BASE = 32'h0010_0000;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    typedef enum logic {
        WIN_FETCH = 1'b0,
        WIN_DATA  = 1'b1
    } winner_e;

endpackage

// File: rtl/arb_prio2.sv
// Two-requester grant selector: data-priority with a fetch starvation bound,
// or alternating winner on contention when ARB_ROUND_ROBIN_EN is defined.
module arb_prio2
    import mem_pkg::*;
#(
    parameter int MAX_STALL = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [3:0] CNT_MAX = 4'd1;
`else
    localparam logic [3:0] CNT_MAX = 4'(MAX_STALL);
`endif

    logic [3:0] stall_cnt;
    logic [3:0] stall_cnt_nxt;
    winner_e    last_win;
    winner_e    last_win_nxt;
    logic       contended;
    logic       fetch_wins;

    assign contended = i_req & d_req;

    always_comb begin
        i_gnt         = 1'b0;
        d_gnt         = 1'b0;
        fetch_wins    = 1'b0;
        last_win_nxt  = last_win;
        stall_cnt_nxt = stall_cnt;

        if (contended) begin
`ifdef ARB_ROUND_ROBIN_EN
            fetch_wins = (last_win == WIN_DATA);
`else
            fetch_wins = (stall_cnt == CNT_MAX);
`endif
            i_gnt        = fetch_wins;
            d_gnt        = ~fetch_wins;
            last_win_nxt = fetch_wins ? WIN_FETCH : WIN_DATA;
        end else begin
            i_gnt = i_req;
            d_gnt = d_req;
        end

        // Counts data grants taken while fetch sits waiting
        if (i_gnt || !i_req) begin
            stall_cnt_nxt = 4'd0;
        end else if (d_gnt && (stall_cnt != CNT_MAX)) begin
            stall_cnt_nxt = stall_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= 4'd0;
            last_win  <= WIN_FETCH;
        end else begin
            stall_cnt <= stall_cnt_nxt;
            last_win  <= last_win_nxt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// routing read data back to its owner. Optional macro: ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_STALL = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wd,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    owner_e        owner;
    owner_e        owner_nxt;
    logic [DW-1:0] i_hold;
    logic [DW-1:0] d_hold;

    arb_prio2 #(.MAX_STALL(MAX_STALL)) u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .i_req (i_req),
        .d_req (d_req),
        .i_gnt (i_gnt),
        .d_gnt (d_gnt)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        owner_nxt = OWN_NONE;
        if (i_gnt) begin
            mem_addr  = i_addr;
            owner_nxt = OWN_FETCH;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wd    = d_wd;
            mem_we    = d_we;
            owner_nxt = d_we ? OWN_NONE : OWN_DATA;
        end
    end

    // Memory data arrives the cycle after the grant, so the owner register
    // steers it straight through; the hold registers keep the last word seen.
    assign i_rvalid = (owner == OWN_FETCH);
    assign d_rvalid = (owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? mem_rd : i_hold;
    assign d_rdata  = d_rvalid ? mem_rd : d_hold;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner  <= OWN_NONE;
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            owner  <= owner_nxt;
            i_hold <= i_rdata;
            d_hold <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter against a behavioural model.
// Build with or without ARB_ROUND_ROBIN_EN; the model follows the same macro.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_STALL = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wd = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd = '0;

    int n_vec = 0;
    int n_mis = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_STALL(MAX_STALL)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wd     (d_wd),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    // ---------------- clock / memory responder ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
    endfunction

    always @(posedge clk) mem_rd <= mem_fn(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    int          m_cnt = 0;
    bit          m_last_data = 1'b0;
    int          m_own = 0;          // 0 none, 1 fetch, 2 data
    logic [31:0] m_ihold = '0;
    logic [31:0] m_dhold = '0;
    logic [31:0] exp_q[$];

`ifdef ARB_ROUND_ROBIN_EN
    localparam int CNT_LIM = 1;
`else
    localparam int CNT_LIM = MAX_STALL;
`endif

    always @(negedge clk) begin : cmp
        logic        ig, dg, fetch_first;
        logic [31:0] ed;
        if (!rstn) begin
            m_cnt = 0; m_last_data = 1'b0; m_own = 0;
            m_ihold = '0; m_dhold = '0;
            exp_q.delete();
            chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
            chk("rst_i_rdata", i_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
        end else begin
            if (m_own != 0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                    ed = '0;
                end else begin
                    ed = exp_q.pop_front();
                end
                if (m_own == 1) m_ihold = ed;
                else m_dhold = ed;
            end
            chk("i_rvalid", 32'(i_rvalid), 32'(m_own == 1));
            chk("d_rvalid", 32'(d_rvalid), 32'(m_own == 2));
            chk("i_rdata", i_rdata, m_ihold);
            chk("d_rdata", d_rdata, m_dhold);

            if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                fetch_first = m_last_data;
`else
                fetch_first = (m_cnt == MAX_STALL);
`endif
                ig = fetch_first;
                dg = !fetch_first;
                m_last_data = dg;
            end else begin
                ig = i_req;
                dg = d_req;
            end
            chk("i_gnt", 32'(i_gnt), 32'(ig));
            chk("d_gnt", 32'(d_gnt), 32'(dg));
            chk("mem_addr", mem_addr, ig ? i_addr : (dg ? d_addr : 32'd0));
            chk("mem_wd", mem_wd, dg && !ig ? d_wd : 32'd0);
            chk("mem_we", 32'(mem_we), 32'(dg && d_we));

            if (ig || !i_req) m_cnt = 0;
            else if (dg && m_cnt < CNT_LIM) m_cnt++;

            if (ig) begin
                m_own = 1; exp_q.push_back(mem_fn(i_addr));
            end else if (dg && !d_we) begin
                m_own = 2; exp_q.push_back(mem_fn(d_addr));
            end else begin
                m_own = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        i_req = ir; i_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wd = dd;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic ig_s, dg_s, exp_f;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("lit_reset_mem_we", 32'(mem_we), 32'd0);
        chk("lit_reset_rdata", i_rdata | d_rdata, 32'd0);

        // single fetch
        drive(1'b1, ROM_BASE, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("lit_fetch_gnt", 32'(i_gnt), 32'd1);
        chk("lit_fetch_addr", mem_addr, 32'h0001_0000);
        idle();
        @(negedge clk);
        chk("lit_fetch_rvalid", 32'(i_rvalid), 32'd1);
        chk("lit_fetch_rdata", i_rdata, 32'h5A5A_A4A5);

        // single store
        drive(1'b0, 32'd0, 1'b1, 1'b1, RAM_BASE + 32'd4, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lit_store_gnt", 32'(d_gnt), 32'd1);
        chk("lit_store_we", 32'(mem_we), 32'd1);
        chk("lit_store_wd", mem_wd, 32'hDEAD_BEEF);
        idle();
        @(negedge clk);
        chk("lit_store_no_rvalid", 32'(d_rvalid), 32'd0);

        // sustained contention with loads
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, ROM_BASE + 32'd8, 1'b1, 1'b0, RAM_BASE + 32'd12, 32'd0);
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            exp_f = (k % 2) == 1;
`else
            exp_f = (k % 5) == 4;
`endif
            chk("lit_contend_i_gnt", 32'(i_gnt), 32'(exp_f));
            chk("lit_contend_d_gnt", 32'(d_gnt), 32'(!exp_f));
        end
        idle();

        // back-to-back fetches
        drive(1'b1, ROM_BASE, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, ROM_BASE + 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("lit_b2b_rvalid0", 32'(i_rvalid), 32'd1);
        chk("lit_b2b_rdata0", i_rdata, 32'h5A5A_A4A5);
        idle();
        @(negedge clk);
        chk("lit_b2b_rvalid1", 32'(i_rvalid), 32'd1);
        chk("lit_b2b_rdata1", i_rdata, 32'h5E5A_A4A5);

        // reset in the cycle after a load grant
        drive(1'b0, 32'd0, 1'b1, 1'b0, RAM_BASE + 32'd8, 32'd0);
        @(negedge clk);
        chk("lit_load_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        chk("lit_rst_drop_rvalid", 32'(d_rvalid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("lit_post_rst_rvalid", 32'(d_rvalid), 32'd0);
        chk("lit_post_rst_we", 32'(mem_we), 32'd0);
        chk("lit_post_rst_rdata", d_rdata, 32'd0);

        // randomised traffic, requests held until granted or occasionally withdrawn
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ig_s = i_gnt;
            dg_s = d_gnt;
            @(posedge clk);
            #1;
            if (n == 1500) rstn = 1'b0;
            if (n == 1502) rstn = 1'b1;
            if (!i_req || ig_s || $urandom_range(15) == 0) begin
                i_req  = ($urandom_range(3) != 0);
                i_addr = ROM_BASE + 32'($urandom_range(1023)) * 32'd4;
            end
            if (!d_req || dg_s || $urandom_range(15) == 0) begin
                d_req  = ($urandom_range(3) != 0);
                d_we   = ($urandom_range(2) == 0);
                d_addr = RAM_BASE + 32'($urandom_range(1023)) * 32'd4;
                d_wd   = $urandom;
            end
        end
        idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
